// File: rtl/ahfp_mult_seq.sv
// ahfp_mult_seq: multi-cycle floating-point multiplier with start/done handshake.
// Pipeline of FSM states IDLE->UNPACK->MULT->NORM->ROUND->DONE; five clocks from
// accept to done. Denormals are flushed to zero; results that underflow are flushed.
// Optional feature macro: AHFP_MULT_RNE_EN (round-to-nearest-even; default truncates).
module ahfp_mult_seq #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clk_en,
  input  logic                   start,
  input  logic [EXP_W+MAN_W:0]   dataa,
  input  logic [EXP_W+MAN_W:0]   datab,
  output logic [EXP_W+MAN_W:0]   result,
  output logic                   done
);

  localparam int W    = 1 + EXP_W + MAN_W;
  localparam int P_W  = 2 * (MAN_W + 1);
  localparam int XE_W = EXP_W + 2;
  localparam int BIAS = (2 ** (EXP_W - 1)) - 1;
  localparam int EMAX = (2 ** EXP_W) - 1;

  localparam logic [XE_W-1:0] BIAS_X = XE_W'(BIAS);
  localparam logic [XE_W-1:0] EMAX_X = XE_W'(EMAX);
  localparam logic [XE_W-1:0] ONE_X  = XE_W'(1);
  localparam logic [XE_W-1:0] ZERO_X = {XE_W{1'b0}};
  localparam logic [W-1:0]    QNAN   = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  // Operand class carried from UNPACK to the final packing step
  localparam logic [1:0] CLS_NUM  = 2'd0;
  localparam logic [1:0] CLS_NAN  = 2'd1;
  localparam logic [1:0] CLS_INF  = 2'd2;
  localparam logic [1:0] CLS_ZERO = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_UNPACK = 3'd1,
    S_MULT   = 3'd2,
    S_NORM   = 3'd3,
    S_ROUND  = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t           r_state, w_next;
  logic [W-1:0]     r_a, r_b;
  logic             r_sign;
  logic [1:0]       r_cls;
  logic [EXP_W-1:0] r_ea, r_eb;
  logic [MAN_W:0]   r_ma, r_mb;
  logic [P_W-1:0]   r_prod;
  logic [XE_W-1:0]  r_exp;
  logic [MAN_W:0]   r_man;
  logic             r_g, r_r, r_s;
  logic [W-1:0]     r_result;
  logic             r_done;

  // Field split and classification of the latched operands
  logic [EXP_W-1:0] w_ea, w_eb;
  logic [MAN_W-1:0] w_fa, w_fb;
  logic             w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;
  logic [1:0]       w_cls;

  assign w_ea = r_a[W-2:MAN_W];
  assign w_eb = r_b[W-2:MAN_W];
  assign w_fa = r_a[MAN_W-1:0];
  assign w_fb = r_b[MAN_W-1:0];
  // A zero exponent covers both true zero and denormals, which are flushed
  assign w_a_zero = (w_ea == {EXP_W{1'b0}});
  assign w_b_zero = (w_eb == {EXP_W{1'b0}});
  assign w_a_inf  = (w_ea == {EXP_W{1'b1}}) && (w_fa == {MAN_W{1'b0}});
  assign w_b_inf  = (w_eb == {EXP_W{1'b1}}) && (w_fb == {MAN_W{1'b0}});
  assign w_a_nan  = (w_ea == {EXP_W{1'b1}}) && (w_fa != {MAN_W{1'b0}});
  assign w_b_nan  = (w_eb == {EXP_W{1'b1}}) && (w_fb != {MAN_W{1'b0}});

  // Special-value priority: NaN (incl. inf x zero) over inf over zero
  always_comb begin
    w_cls = CLS_NUM;
    if (w_a_nan || w_b_nan || (w_a_inf && w_b_zero) || (w_b_inf && w_a_zero)) begin
      w_cls = CLS_NAN;
    end else if (w_a_inf || w_b_inf) begin
      w_cls = CLS_INF;
    end else if (w_a_zero || w_b_zero) begin
      w_cls = CLS_ZERO;
    end else begin
      w_cls = CLS_NUM;
    end
  end

  // Rounding increment; truncation build ignores guard/round/sticky entirely
  logic w_inc;
`ifdef AHFP_MULT_RNE_EN
  assign w_inc = r_g & (r_r | r_s | r_man[0]);
`else
  assign w_inc = &{1'b0, r_g, r_r, r_s};
`endif

  logic [MAN_W+1:0] w_sum;
  logic [MAN_W-1:0] w_frac;
  logic [XE_W-1:0]  w_exp_fin;
  logic [W-1:0]     w_res;

  assign w_sum = {1'b0, r_man} + {{(MAN_W+1){1'b0}}, w_inc};

  // Renormalise on mantissa carry-out, then pack the final result
  always_comb begin
    w_frac    = w_sum[MAN_W-1:0];
    w_exp_fin = r_exp;
    w_res     = {W{1'b0}};
    if (w_sum[MAN_W+1]) begin
      w_frac    = w_sum[MAN_W:1];
      w_exp_fin = r_exp + ONE_X;
    end else begin
      w_frac    = w_sum[MAN_W-1:0];
      w_exp_fin = r_exp;
    end
    case (r_cls)
      CLS_NAN:  w_res = QNAN;
      CLS_INF:  w_res = {r_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      CLS_ZERO: w_res = {r_sign, {(W-1){1'b0}}};
      CLS_NUM: begin
        if ($signed(w_exp_fin) >= $signed(EMAX_X)) begin
          w_res = {r_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if ($signed(w_exp_fin) <= $signed(ZERO_X)) begin
          w_res = {r_sign, {(W-1){1'b0}}};
        end else begin
          w_res = {r_sign, w_exp_fin[EXP_W-1:0], w_frac};
        end
      end
      default:  w_res = QNAN;
    endcase
  end

  // Next-state logic: fixed walk through the pipeline, accept only in IDLE
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (start) w_next = S_UNPACK; else w_next = S_IDLE;
      S_UNPACK: w_next = S_MULT;
      S_MULT:   w_next = S_NORM;
      S_NORM:   w_next = S_ROUND;
      S_ROUND:  w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // State register; clk_en low freezes the sequence
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else if (clk_en) begin
      r_state <= w_next;
    end
  end

  // Datapath registers, each stage updated on the edge that leaves its state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a      <= {W{1'b0}};
      r_b      <= {W{1'b0}};
      r_sign   <= 1'b0;
      r_cls    <= CLS_NUM;
      r_ea     <= {EXP_W{1'b0}};
      r_eb     <= {EXP_W{1'b0}};
      r_ma     <= {(MAN_W+1){1'b0}};
      r_mb     <= {(MAN_W+1){1'b0}};
      r_prod   <= {P_W{1'b0}};
      r_exp    <= {XE_W{1'b0}};
      r_man    <= {(MAN_W+1){1'b0}};
      r_g      <= 1'b0;
      r_r      <= 1'b0;
      r_s      <= 1'b0;
      r_result <= {W{1'b0}};
      r_done   <= 1'b0;
    end else if (clk_en) begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a <= dataa;
            r_b <= datab;
          end
        end
        S_UNPACK: begin
          r_sign <= r_a[W-1] ^ r_b[W-1];
          r_cls  <= w_cls;
          r_ea   <= w_ea;
          r_eb   <= w_eb;
          r_ma   <= {1'b1, w_fa};
          r_mb   <= {1'b1, w_fb};
        end
        S_MULT: begin
          r_prod <= {{(MAN_W+1){1'b0}}, r_ma} * {{(MAN_W+1){1'b0}}, r_mb};
          r_exp  <= {2'b00, r_ea} + {2'b00, r_eb} - BIAS_X;
        end
        S_NORM: begin
          // Product of two [1,2) significands lies in [1,4); MSB set means >= 2
          if (r_prod[P_W-1]) begin
            r_man <= r_prod[P_W-1:MAN_W+1];
            r_g   <= r_prod[MAN_W];
            r_r   <= r_prod[MAN_W-1];
            r_s   <= |r_prod[MAN_W-2:0];
            r_exp <= r_exp + ONE_X;
          end else begin
            r_man <= r_prod[P_W-2:MAN_W];
            r_g   <= r_prod[MAN_W-1];
            r_r   <= r_prod[MAN_W-2];
            r_s   <= |r_prod[MAN_W-3:0];
          end
        end
        S_ROUND: begin
          r_result <= w_res;
          r_done   <= 1'b1;
        end
        S_DONE: begin
          r_done <= 1'b0;
        end
        default: begin
          r_done <= 1'b0;
        end
      endcase
    end
  end

  assign result = r_result;
  assign done   = r_done;

endmodule
